mioc_flop_driver: RTL and testbench
===================================

MIOC_FLOP_DRIVER -- requirements
Module: mioc_flop_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving the number of pattern-buffer entries (power of two, 2..256).
REQ-002 SHALL have parameter DWELL, default 100, giving the clk cycles each pattern is held on in1..in4 before sampling (minimum 1).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port clr, input, 1, empties the pattern buffer while in IDLE.
REQ-006 SHALL have port wr_en, input, 1, pattern-buffer write strobe.
REQ-007 SHALL have port wr_data, input, 5, with [4:1] = {in1,in2,in3,in4} pattern and [0] = expected q.
REQ-008 SHALL have port start, input, 1, begins a run over the stored patterns.
REQ-009 SHALL have ports in1, in2, in3, in4, output, 1 each, driven to the flop under test.
REQ-010 SHALL have ports q and qbar, input, 1 each, from the flop under test.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse at the end of a run.
REQ-013 SHALL have ports res_valid (output, 1), res_ready (input, 1) and res_data (output, 6) = {in1,in2,in3,in4,q,qbar}.
REQ-014 SHALL have port err_cnt, output, 8, the saturating error count for the current run.

Function
REQ-015 SHALL implement states IDLE, DRIVE, SAMPLE, EMIT and FIN.
REQ-016 In IDLE, SHALL write wr_data at the write pointer and increment the pointer when wr_en=1; writes while full, or in any other state, are dropped.
REQ-017 SHALL give priority in IDLE as clr > start > wr_en: clr zeroes the write pointer; start drops a same-cycle write.
REQ-018 On start in IDLE with count>0, SHALL clear err_cnt, set index=0, go to DRIVE and present entry 0 on in1..in4 the next cycle.
REQ-019 On start in IDLE with count=0, SHALL go to FIN directly with err_cnt cleared.
REQ-020 SHALL hold in1..in4 constant for exactly DWELL cycles in DRIVE, then go to SAMPLE.
REQ-021 In SAMPLE (1 cycle), SHALL register q and qbar into res_data, increment err_cnt if q==qbar, and go to EMIT.
REQ-022 In EMIT, SHALL assert res_valid and hold res_data stable until res_valid&&res_ready.
REQ-023 On that handshake, SHALL go to DRIVE with index+1, or to FIN if index==count-1.
REQ-024 SHALL keep in1..in4 driven with the current pattern through SAMPLE and EMIT.
REQ-025 In FIN, SHALL pulse done for 1 cycle and then return to IDLE; buffer contents and count are retained.
REQ-026 SHALL saturate err_cnt at 255, hold its value after a run, and clear it only on start or rst.
REQ-027 SHALL ignore start when busy=1.

Reset
REQ-028 On rst, the next edge SHALL force IDLE, write pointer 0, index 0, in1..in4=0, res_valid=0, res_data=0, done=0, busy=0 and err_cnt=0, aborting any run in progress with no done pulse.
REQ-029 SHALL NOT clear buffer storage on reset.

Configuration
REQ-030 SHALL compile the expected-value check in when MIOC_FLOP_DRIVER_COMPARE_EN is defined.
REQ-031 With MIOC_FLOP_DRIVER_COMPARE_EN defined, SAMPLE SHALL also increment err_cnt when q != wr_data[0] of the entry, adding at most 1 per pattern.
REQ-032 Without MIOC_FLOP_DRIVER_COMPARE_EN, SHALL store and ignore wr_data[0], and only q==qbar counts as an error.

Structure
REQ-033 SHALL place the state encoding, the res_data field offsets and the err_cnt width in shared package mioc_pkg.
REQ-034 SHALL implement the pattern buffer as sub-module mioc_pat_buf: DEPTH x 5, one write port and one asynchronous read port.

Verification
REQ-035 Load 0000,0101,1010,1111 with a model flop, start, res_ready=1 -> 4 results in load order, each preceded by 100 DRIVE cycles, done pulse after the 4th, err_cnt=0.
REQ-036 Force q=qbar=1 on pattern 2 of 4 -> err_cnt=1, with res_data[1:0]=11 on that result.
REQ-037 Hold res_ready=0 for 50 cycles in EMIT -> res_valid and res_data stable, in1..in4 unchanged, no index advance.
REQ-038 Write 17 entries at DEPTH=16, then start -> exactly 16 results; clr then start -> immediate done, err_cnt=0.
REQ-039 Assert rst mid-DRIVE at pattern 3 -> next cycle IDLE, outputs zero, no done pulse; a re-run replays the retained buffer.
REQ-040 With COMPARE_EN, write entry 11001 while the model returns q=0 -> err_cnt=1; without the macro -> err_cnt=0.

Source files
------------

// File: rtl/mioc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mioc_pkg
//  Description : Shared definitions for the flop driver. Includes the state
//                encoding, the res_data field offsets, the pattern-entry
//                width, the err_cnt width and a saturating increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mioc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    // One buffer entry is {in1,in2,in3,in4,expected_q}
    localparam int c_ENTRY_W = 5;

    // res_data = {in1,in2,in3,in4,q,qbar}
    localparam int c_RES_W       = 6;
    localparam int c_RES_QBAR    = 0;
    localparam int c_RES_Q       = 1;
    localparam int c_RES_PAT_LSB = 2;
    localparam int c_RES_PAT_MSB = 5;

    localparam int c_ERR_W = 8;

    // Add one, sticking at all-ones
    function automatic logic [c_ERR_W-1:0] sat_inc(input logic [c_ERR_W-1:0] v);
        return (v == {c_ERR_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mioc_pat_buf.sv
`default_nettype none
// ============================================================================
//  Module      : mioc_pat_buf
//  Description : Pattern storage, DEPTH x 5 bits, one synchronous write port
//                and one asynchronous read port. Contents have no reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mioc_pat_buf
    import mioc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [c_ENTRY_W-1:0] i_wr_data,
    input  logic [AW-1:0]        i_rd_addr,
    output logic [c_ENTRY_W-1:0] o_rd_data
);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/mioc_flop_driver.sv
`default_nettype none
// ============================================================================
//  Module      : mioc_flop_driver
//  Description : Replays stored 4-bit patterns onto a flop under test, holds
//                each for DWELL cycles, samples q/qbar, streams results over
//                a valid/ready port and counts errors (q==qbar).
//                Optional macro MIOC_FLOP_DRIVER_COMPARE_EN also counts an
//                error when q differs from the stored expected bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mioc_flop_driver
    import mioc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DWELL = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [4:0]           wr_data,
    input  logic                 start,
    output logic                 in1,
    output logic                 in2,
    output logic                 in3,
    output logic                 in4,
    input  logic                 q,
    input  logic                 qbar,
    output logic                 busy,
    output logic                 done,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [c_RES_W-1:0]   res_data,
    output logic [c_ERR_W-1:0]   err_cnt
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_IDX_W + 1;
    localparam int c_DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_CNT_W-1:0] c_FULL       = c_CNT_W'(DEPTH);
    localparam logic [c_DW_W-1:0]  c_DWELL_LAST = c_DW_W'(DWELL - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [c_CNT_W-1:0]     r_wr_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_IDX_W-1:0]     r_index;
    logic [c_DW_W-1:0]      r_dwell;
    logic [3:0]             r_pat;
    logic [c_RES_W-1:0]     r_res;
    logic [c_ERR_W-1:0]     r_err;
    logic [c_IDX_W-1:0]     w_rd_addr;
    logic [c_ENTRY_W-1:0]   w_rd_data;
    logic                   w_idle;
    logic                   w_hs;
    logic                   w_is_last;
    logic                   w_wr_ok;
    logic                   w_start_run;
    logic                   w_load;
    logic                   w_err_hit;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_hs        = (r_state == ST_EMIT) && res_ready;
    assign w_is_last   = ({1'b0, r_index} == (r_count - 1'b1));
    assign w_start_run = w_idle && !clr && start;
    assign w_wr_ok     = !rst && w_idle && wr_en && !clr && !start && (r_wr_ptr != c_FULL);
    assign w_load      = (w_start_run && (r_count != '0)) || (w_hs && !w_is_last);
    // Entry 0 when starting, otherwise the entry after the current one
    assign w_rd_addr   = w_idle ? '0 : r_index + 1'b1;

    mioc_pat_buf #(
        .DEPTH (DEPTH)
    ) u_pat_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (r_wr_ptr[c_IDX_W-1:0]),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

`ifdef MIOC_FLOP_DRIVER_COMPARE_EN
    logic r_exp;

    // Capture the expected q alongside the pattern being driven
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp <= 1'b0;
        end else if (w_load) begin
            r_exp <= w_rd_data[0];
        end
    end

    assign w_err_hit = (q == qbar) || (q != r_exp);
`else
    logic w_unused_exp;
    assign w_unused_exp = w_rd_data[0];
    assign w_err_hit    = (q == qbar);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; clr outranks start in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (!clr && start) w_next = (r_count != '0) ? ST_DRIVE : ST_FIN;
            ST_DRIVE:  if (r_dwell == c_DWELL_LAST) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = ST_EMIT;
            ST_EMIT:   if (res_ready) w_next = w_is_last ? ST_FIN : ST_DRIVE;
            ST_FIN:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Entry count survives rst so a run can be replayed after an abort;
    // only clr empties it, and each accepted write sets it to pointer+1
    always_ff @(posedge clk) begin
        if (!rst && w_idle && clr) begin
            r_count <= '0;
        end else if (w_wr_ok) begin
            r_count <= r_wr_ptr + 1'b1;
        end
    end

    // Datapath: write pointer, run index, dwell timer, driven pattern, results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_index  <= '0;
            r_dwell  <= '0;
            r_pat    <= '0;
            r_res    <= '0;
            r_err    <= '0;
        end else begin
            if (w_idle && clr) begin
                r_wr_ptr <= '0;
            end else if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_start_run) begin
                r_err   <= '0;
                r_index <= '0;
            end else if (w_hs && !w_is_last) begin
                r_index <= r_index + 1'b1;
            end

            if (w_load) begin
                r_pat   <= w_rd_data[4:1];
                r_dwell <= '0;
            end else if (r_state == ST_DRIVE) begin
                r_dwell <= r_dwell + 1'b1;
            end

            if (r_state == ST_SAMPLE) begin
                r_res[c_RES_PAT_MSB:c_RES_PAT_LSB] <= r_pat;
                r_res[c_RES_Q]                     <= q;
                r_res[c_RES_QBAR]                  <= qbar;
                if (w_err_hit) begin
                    r_err <= sat_inc(r_err);
                end
            end
        end
    end

    assign in1       = r_pat[3];
    assign in2       = r_pat[2];
    assign in3       = r_pat[1];
    assign in4       = r_pat[0];
    assign busy      = !w_idle;
    assign done      = (r_state == ST_FIN);
    assign res_valid = (r_state == ST_EMIT);
    assign res_data  = r_res;
    assign err_cnt   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mioc_flop_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mioc_flop_driver
//  Description : Self-checking bench for mioc_flop_driver: table vectors,
//                hand sequences for stall/overflow/abort, randomized runs
//                against a behavioural buffer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mioc_flop_driver;

    localparam int DEPTH = 16;
    localparam int DWELL = 100;
`ifdef MIOC_FLOP_DRIVER_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, clr, wr_en, start, res_ready, force_err;
    logic [4:0] wr_data;
    logic       q, qbar;
    logic       in1, in2, in3, in4, busy, done, res_valid;
    logic [5:0] res_data;
    logic [7:0] err_cnt;
    logic [3:0] pins;

    always #5 clk = ~clk;

    mioc_flop_driver #(.DEPTH(DEPTH), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .start(start), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .q(q), .qbar(qbar), .busy(busy), .done(done), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .err_cnt(err_cnt)
    );

    // Model flop under test: settled q as a fixed function of the pattern
    function automatic logic flop_fn(input logic [3:0] p);
        return (p[3] & p[0]) | (~p[3] & p[2] & p[1]);
    endfunction

    assign pins = {in1, in2, in3, in4};
    assign q    = force_err ? 1'b1 : flop_fn(pins);
    assign qbar = force_err ? 1'b1 : ~flop_fn(pins);

    typedef struct {
        logic [4:0] wd;
        bit         frc;
        logic [1:0] qq;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [4:0] mbuf [256];
    bit         frc  [256];
    int         mptr = 0;
    int         mcount = 0;
    logic [5:0] obs [$];
    vec_t       tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [4:0] d);
        wr_data = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        if (mptr < DEPTH) begin
            mbuf[mptr] = d;
            mptr++;
            mcount = mptr;
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mptr = 0; mcount = 0;
        for (int i = 0; i < 256; i++) frc[i] = 1'b0;
    endtask

    function automatic int model_err();
        int   e = 0;
        logic mq;
        for (int k = 0; k < mcount; k++) begin
            mq = frc[k] ? 1'b1 : flop_fn(mbuf[k][4:1]);
            if (frc[k] || (CMP && (mq != mbuf[k][0]))) e++;
        end
        return (e > 255) ? 255 : e;
    endfunction

    function automatic logic [5:0] model_res(input int k);
        logic f;
        f = flop_fn(mbuf[k][4:1]);
        return {mbuf[k][4:1], frc[k] ? 2'b11 : {f, ~f}};
    endfunction

    // Start a run and follow it result by result; abort_at = pattern index at
    // which rst is pulsed 10 cycles into its DRIVE phase (-1 = never)
    task automatic run(input int st_min, input int st_max, input bit noise, input int abort_at);
        int         lat, st;
        bit         stable;
        logic [5:0] held;
        logic [3:0] hpins;
        obs.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (mcount == 0) begin
            chk("empty_done", done, 1);
            chk("empty_err", err_cnt, 0);
            tick();
            chk("empty_idle", {busy, done}, 0);
            return;
        end
        for (int k = 0; k < mcount; k++) begin
            force_err = frc[k];
            chk("drive_pins", pins, mbuf[k][4:1]);
            lat = 0;
            while (!res_valid && lat < DWELL + 20) begin
                if (noise && lat == 5) begin
                    start = 1'b1; wr_en = 1'b1; wr_data = 5'($urandom);
                end
                tick();
                start = 1'b0; wr_en = 1'b0;
                lat++;
                if (abort_at == k && lat == 10) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    force_err = 1'b0;
                    mptr = 0;
                    chk("abort_outputs", {busy, done, res_valid, pins, res_data, err_cnt}, 0);
                    stable = 1'b1;
                    for (int i = 0; i < 5; i++) begin
                        tick();
                        if (done !== 1'b0 || busy !== 1'b0) stable = 1'b0;
                    end
                    chk("abort_no_done", stable, 1);
                    return;
                end
            end
            chk("latency", lat, DWELL + 1);
            if (!res_valid) return;
            held = res_data; hpins = pins;
            st = $urandom_range(st_max, st_min);
            stable = 1'b1;
            for (int s = 0; s < st; s++) begin
                tick();
                if (res_valid !== 1'b1 || res_data !== held || pins !== hpins) stable = 1'b0;
            end
            if (st > 0) chk("stall_stable", stable, 1);
            obs.push_back(res_data);
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            force_err = 1'b0;
            if (k == mcount - 1) begin
                chk("done_pulse", {done, busy}, 2'b11);
                tick();
                chk("done_low", {done, busy}, 0);
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_count"}, obs.size(), mcount);
        for (int i = 0; i < obs.size() && i < mcount; i++) chk({tag, "_res"}, obs[i], model_res(i));
        chk({tag, "_err"}, err_cnt, model_err());
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] p;
        int         n;
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0;
        res_ready = 1'b0; force_err = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_outputs", {busy, done, res_valid, pins, res_data, err_cnt}, 0);
        do_clr();

        // Table: q,qbar hand-derived from the flop function; second pass
        // forces q=qbar=1 on pattern 2
        tbl[0] = '{5'b0000_0, 1'b0, 2'b01};
        tbl[1] = '{5'b0101_0, 1'b0, 2'b01};
        tbl[2] = '{5'b1010_0, 1'b0, 2'b01};
        tbl[3] = '{5'b1111_1, 1'b0, 2'b10};
        tbl[4] = '{5'b0000_0, 1'b0, 2'b01};
        tbl[5] = '{5'b0101_0, 1'b1, 2'b11};
        tbl[6] = '{5'b1010_0, 1'b0, 2'b01};
        tbl[7] = '{5'b1111_1, 1'b0, 2'b10};
        for (int r = 0; r < 2; r++) begin
            do_clr();
            for (int i = 0; i < 4; i++) begin
                write_entry(tbl[4*r+i].wd);
                frc[i] = tbl[4*r+i].frc;
            end
            run(0, 0, 1'b0, -1);
            chk("tbl_count", obs.size(), 4);
            for (int i = 0; i < obs.size() && i < 4; i++)
                chk("tbl_res", obs[i], {tbl[4*r+i].wd[4:1], tbl[4*r+i].qq});
            chk("tbl_err", err_cnt, r);
        end

        // Long back-pressure in EMIT
        for (int i = 0; i < 4; i++) frc[i] = 1'b0;
        run(50, 50, 1'b0, -1);
        check_model("stall");

        // Overflow: 17 writes keep 16; then clr gives an empty run
        do_clr();
        for (int i = 0; i < 17; i++) begin
            p = 4'($urandom);
            write_entry({p, flop_fn(p)});
        end
        chk("full_count", mcount, DEPTH);
        run(0, 1, 1'b0, -1);
        check_model("full");
        do_clr();
        run(0, 0, 1'b0, -1);

        // Abort at pattern 3, then replay the retained buffer
        do_clr();
        for (int i = 0; i < 4; i++) write_entry(tbl[i].wd);
        run(0, 0, 1'b0, 2);
        run(0, 0, 1'b0, -1);
        check_model("replay");

        // Expected-bit mismatch: entry 1100 expects 1, flop returns 0
        do_clr();
        write_entry(5'b1100_1);
        run(0, 0, 1'b0, -1);
        chk("cmp_err", err_cnt, CMP ? 1 : 0);

        // Randomized runs with start/write noise while busy
        for (int it = 0; it < 6; it++) begin
            do_clr();
            n = $urandom_range(18, 1);
            for (int i = 0; i < n; i++) begin
                p = 4'($urandom);
                write_entry({p, flop_fn(p) ^ ($urandom_range(7, 0) == 0)});
            end
            for (int i = 0; i < mcount; i++) frc[i] = ($urandom_range(3, 0) == 0);
            run(0, 3, 1'b1, -1);
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
